// File: rtl/caliptra_fpga_step_pkg.sv
// rtl/caliptra_fpga_step_pkg.sv - shared types for the FPGA clock-step controller
package caliptra_fpga_step_pkg;

  // Status fields are sized for the widest supported build; channels zero-extend.
  localparam int STAT_CNT_W = 64;
  localparam int STAT_TS_W  = 64;

  typedef enum logic [1:0] {
    OP_STEP = 2'd0,
    OP_RUN  = 2'd1,
    OP_HALT = 2'd2,
    OP_CLR  = 2'd3
  } step_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } step_state_e;

  typedef struct packed {
    logic                  clk_en;
    logic                  busy;
    logic [STAT_CNT_W-1:0] remaining;
    logic [STAT_TS_W-1:0]  gated_cycles;
    logic                  done_pulse;
    logic                  bkpt_hit;
  } step_status_t;

endpackage

// File: rtl/caliptra_fpga_step_chan.sv
// rtl/caliptra_fpga_step_chan.sv - one gated-clock channel: FSM, counters, breakpoint
module caliptra_fpga_step_chan
  import caliptra_fpga_step_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TS_W  = 64
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             cmd_step,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_clr,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             bkpt_en,
  input  logic [TS_W-1:0]  bkpt_val,
  output step_status_t     status
);

  step_state_e      state_q, state_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [TS_W-1:0]  gated_q, gated_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             bkpt_fire;

  // The breakpoint cycle is itself enabled, so it lands one short of bkpt_val.
  assign bkpt_fire = bkpt_en && en_q && (gated_q == bkpt_val - TS_W'(1));

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      remaining_q <= '0;
      gated_q     <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      remaining_q <= remaining_d;
      gated_q     <= gated_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    gated_d     = gated_q + TS_W'(en_q);

    if (bkpt_fire) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      done_d      = 1'b1;
      hit_d       = 1'b1;
    end else if (state_q == ST_STEP) begin
      if (remaining_q == CNT_W'(1)) begin
        state_d     = ST_IDLE;
        remaining_d = '0;
        done_d      = 1'b1;
      end else begin
        remaining_d = remaining_q - CNT_W'(1);
      end
    end

    // An accepted command overrides both step expiry and breakpoint stop.
    if (cmd_step) begin
      hit_d = 1'b0;
      if (cmd_count == '0) begin
        state_d     = ST_IDLE;
        remaining_d = '0;
        done_d      = 1'b1;
      end else begin
        state_d     = ST_STEP;
        remaining_d = cmd_count;
        done_d      = 1'b0;
      end
    end else if (cmd_run) begin
      hit_d       = 1'b0;
      state_d     = ST_RUN;
      remaining_d = '0;
      done_d      = 1'b0;
    end else if (cmd_halt && en_q) begin
      hit_d       = hit_q;
      state_d     = ST_IDLE;
      remaining_d = '0;
      done_d      = 1'b1;
    end

    if (cmd_clr) begin
      gated_d = '0;
    end

    en_d = (state_d != ST_IDLE);
  end

  always_comb begin
    status              = '0;
    status.clk_en       = en_q;
    status.busy         = en_q;
    status.remaining    = STAT_CNT_W'(remaining_q);
    status.gated_cycles = STAT_TS_W'(gated_q);
    status.done_pulse   = done_q;
    status.bkpt_hit     = hit_q;
  end

endmodule

// File: rtl/caliptra_fpga_step_ctrl.sv
// rtl/caliptra_fpga_step_ctrl.sv - multi-channel clock-step controller top
module caliptra_fpga_step_ctrl
  import caliptra_fpga_step_pkg::*;
#(
  parameter int  NUM_CH = 2,
  parameter int  CNT_W  = 32,
  parameter int  TS_W   = 64,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic [1:0]              cmd_op,
  input  logic [CNT_W-1:0]        cmd_count,
  input  logic [NUM_CH-1:0]       bkpt_en,
  input  logic [NUM_CH*TS_W-1:0]  bkpt_val,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*CNT_W-1:0] remaining,
  output logic [NUM_CH*TS_W-1:0]  gated_cycles,
  output logic [NUM_CH-1:0]       done_pulse,
  output logic [NUM_CH-1:0]       bkpt_hit
);

  logic     accept;
  step_op_e op;

  assign cmd_ready = ~rst;
  assign accept    = cmd_valid && cmd_ready;
  assign op        = step_op_e'(cmd_op);

  step_status_t        ch_status [NUM_CH];
  logic [NUM_CH-1:0]   unused_status;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;

    // Out-of-range channel numbers match no instance and are silently dropped.
    assign sel = accept && (cmd_ch == CH_W'(i));

    caliptra_fpga_step_chan #(
      .CNT_W (CNT_W),
      .TS_W  (TS_W)
    ) u_chan (
      .aclk      (aclk),
      .rst       (rst),
      .cmd_step  (sel && (op == OP_STEP)),
      .cmd_run   (sel && (op == OP_RUN)),
      .cmd_halt  (sel && (op == OP_HALT)),
      .cmd_clr   (sel && (op == OP_CLR)),
      .cmd_count (cmd_count),
      .bkpt_en   (bkpt_en[i]),
      .bkpt_val  (bkpt_val[i*TS_W +: TS_W]),
      .status    (ch_status[i])
    );

    assign clk_en[i]                     = ch_status[i].clk_en;
    assign busy[i]                       = ch_status[i].busy;
    assign remaining[i*CNT_W +: CNT_W]   = ch_status[i].remaining[CNT_W-1:0];
    assign gated_cycles[i*TS_W +: TS_W]  = ch_status[i].gated_cycles[TS_W-1:0];
    assign done_pulse[i]                 = ch_status[i].done_pulse;
    assign bkpt_hit[i]                   = ch_status[i].bkpt_hit;
    // Zero-extension bits above CNT_W/TS_W are intentionally dropped.
    assign unused_status[i]              = ^ch_status[i];
  end

endmodule

// File: tb/tb_caliptra_fpga_step_ctrl.sv
// tb/tb_caliptra_fpga_step_ctrl.sv - directed self-checking bench for caliptra_fpga_step_ctrl
module tb_caliptra_fpga_step_ctrl;

  localparam int M_CH = 2, M_CNT = 32, M_TS = 64;
  localparam int S_CH = 1, S_CNT = 8,  S_TS = 8;

  logic aclk = 1'b0;
  logic rst  = 1'b1;
  always #5 aclk = ~aclk;

  logic                 m_cmd_valid, m_cmd_ready;
  logic [0:0]           m_cmd_ch;
  logic [1:0]           m_cmd_op;
  logic [M_CNT-1:0]     m_cmd_count;
  logic [M_CH-1:0]      m_bkpt_en;
  logic [M_CH*M_TS-1:0] m_bkpt_val;
  logic [M_CH-1:0]      m_clk_en, m_busy, m_done, m_hit;
  logic [M_CH*M_CNT-1:0] m_rem;
  logic [M_CH*M_TS-1:0] m_gated;

  logic                 s_cmd_valid, s_cmd_ready;
  logic [0:0]           s_cmd_ch;
  logic [1:0]           s_cmd_op;
  logic [S_CNT-1:0]     s_cmd_count;
  logic [S_CH-1:0]      s_bkpt_en;
  logic [S_CH*S_TS-1:0] s_bkpt_val;
  logic [S_CH-1:0]      s_clk_en, s_busy, s_done, s_hit;
  logic [S_CH*S_CNT-1:0] s_rem;
  logic [S_CH*S_TS-1:0] s_gated;

  caliptra_fpga_step_ctrl #(.NUM_CH(M_CH), .CNT_W(M_CNT), .TS_W(M_TS)) u_dut (
    .aclk(aclk), .rst(rst), .cmd_valid(m_cmd_valid), .cmd_ready(m_cmd_ready),
    .cmd_ch(m_cmd_ch), .cmd_op(m_cmd_op), .cmd_count(m_cmd_count),
    .bkpt_en(m_bkpt_en), .bkpt_val(m_bkpt_val), .clk_en(m_clk_en), .busy(m_busy),
    .remaining(m_rem), .gated_cycles(m_gated), .done_pulse(m_done), .bkpt_hit(m_hit)
  );

  caliptra_fpga_step_ctrl #(.NUM_CH(S_CH), .CNT_W(S_CNT), .TS_W(S_TS)) u_dut_small (
    .aclk(aclk), .rst(rst), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_ch(s_cmd_ch), .cmd_op(s_cmd_op), .cmd_count(s_cmd_count),
    .bkpt_en(s_bkpt_en), .bkpt_val(s_bkpt_val), .clk_en(s_clk_en), .busy(s_busy),
    .remaining(s_rem), .gated_cycles(s_gated), .done_pulse(s_done), .bkpt_hit(s_hit)
  );

  localparam int OP_STEP = 0, OP_RUN = 1, OP_HALT = 2, OP_CLR = 3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_issue(input int ch, input int op, input int cnt);
    @(negedge aclk);
    m_cmd_valid = 1'b1;
    m_cmd_ch    = ch[0:0];
    m_cmd_op    = op[1:0];
    m_cmd_count = cnt;
    @(posedge aclk);
    #1 m_cmd_valid = 1'b0;
  endtask

  task automatic s_issue(input int ch, input int op, input int cnt);
    @(negedge aclk);
    s_cmd_valid = 1'b1;
    s_cmd_ch    = ch[0:0];
    s_cmd_op    = op[1:0];
    s_cmd_count = cnt[S_CNT-1:0];
    @(posedge aclk);
    #1 s_cmd_valid = 1'b0;
  endtask

  task automatic m_window(input int ch, input int n, output int en, output int pulses);
    en = 0; pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      if (m_clk_en[ch]) en++;
      if (m_done[ch]) pulses++;
    end
  endtask

  task automatic s_window(input int n, output int en, output int pulses);
    en = 0; pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      if (s_clk_en[0]) en++;
      if (s_done[0]) pulses++;
    end
  endtask

  initial begin
    int en, pulses;
    m_cmd_valid = 0; m_cmd_ch = 0; m_cmd_op = 0; m_cmd_count = 0;
    m_bkpt_en = 0; m_bkpt_val = '0;
    s_cmd_valid = 0; s_cmd_ch = 0; s_cmd_op = 0; s_cmd_count = 0;
    s_bkpt_en = 0; s_bkpt_val = '0;

    #12;
    check_eq("rst_ready",  m_cmd_ready, 0);
    check_eq("rst_clk_en", m_clk_en, 0);
    check_eq("rst_gated",  m_gated[63:0], 0);
    check_eq("rst_done",   m_done, 0);
    check_eq("rst_s_rdy",  s_cmd_ready, 0);
    @(negedge aclk); rst = 1'b0;
    #1 check_eq("ready_after_rst", m_cmd_ready, 1);

    // STEP ch0 count 5
    m_issue(0, OP_STEP, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check_eq("step5_en",   m_clk_en[0], 1);
      check_eq("step5_busy", m_busy[0], 1);
      check_eq("step5_rem",  m_rem[31:0], 64'(5 - k));
      check_eq("step5_ch1",  m_clk_en[1], 0);
      check_eq("step5_done", m_done[0], 0);
    end
    @(negedge aclk);
    check_eq("step5_end_en",   m_clk_en[0], 0);
    check_eq("step5_end_done", m_done[0], 1);
    check_eq("step5_gated",    m_gated[63:0], 5);
    check_eq("step5_rem0",     m_rem[31:0], 0);
    check_eq("step5_g1",       m_gated[127:64], 0);
    @(negedge aclk);
    check_eq("step5_done_1cyc", m_done[0], 0);

    // STEP ch1 count 0
    m_issue(1, OP_STEP, 0);
    @(negedge aclk);
    check_eq("step0_en",    m_clk_en[1], 0);
    check_eq("step0_done",  m_done[1], 1);
    check_eq("step0_gated", m_gated[127:64], 0);

    // RUN ch0 to breakpoint 20 starting at 5
    m_bkpt_en = 2'b01;
    m_bkpt_val[63:0] = 64'd20;
    m_issue(0, OP_RUN, 0);
    m_window(0, 25, en, pulses);
    check_eq("bkpt_en_cycles", 64'(en), 15);
    check_eq("bkpt_pulses",    64'(pulses), 1);
    check_eq("bkpt_hit",       m_hit[0], 1);
    check_eq("bkpt_gated",     m_gated[63:0], 20);
    check_eq("bkpt_hit_ch1",   m_hit[1], 0);
    m_issue(0, OP_STEP, 2);
    @(negedge aclk);
    check_eq("bkpt_clr_hit", m_hit[0], 0);
    check_eq("bkpt_step_rem", m_rem[31:0], 2);
    m_window(0, 5, en, pulses);
    check_eq("step2_en",    64'(en), 1);
    check_eq("step2_pulse", 64'(pulses), 1);
    check_eq("step2_gated", m_gated[63:0], 22);
    m_bkpt_en = 2'b00;

    // RUN ch1, HALT after 7 enabled cycles
    m_issue(1, OP_RUN, 0);
    repeat (6) @(posedge aclk);
    m_issue(1, OP_HALT, 0);
    @(negedge aclk);
    check_eq("halt_en",    m_clk_en[1], 0);
    check_eq("halt_done",  m_done[1], 1);
    check_eq("halt_gated", m_gated[127:64], 7);
    check_eq("halt_rem",   m_rem[63:32], 0);
    m_window(1, 3, en, pulses);
    check_eq("halt_no_repeat", 64'(pulses), 0);
    m_issue(1, OP_HALT, 0);
    m_window(1, 4, en, pulses);
    check_eq("halt_idle_pulse", 64'(pulses), 0);
    check_eq("halt_idle_en",    64'(en), 0);

    // Retrigger STEP 10 with STEP 3 at its 4th enabled cycle
    m_issue(0, OP_STEP, 10);
    repeat (3) @(posedge aclk);
    m_issue(0, OP_STEP, 3);
    @(negedge aclk);
    check_eq("retrig_en",  m_clk_en[0], 1);
    check_eq("retrig_rem", m_rem[31:0], 3);
    check_eq("retrig_no_done", m_done[0], 0);
    m_window(0, 8, en, pulses);
    check_eq("retrig_tail_en", 64'(en), 2);
    check_eq("retrig_pulses",  64'(pulses), 1);
    check_eq("retrig_gated",   m_gated[63:0], 29);

    // CLR during an enabled cycle
    m_issue(1, OP_RUN, 0);
    repeat (2) @(posedge aclk);
    m_issue(1, OP_CLR, 0);
    @(negedge aclk);
    check_eq("clr_gated",   m_gated[127:64], 0);
    check_eq("clr_keep_en", m_clk_en[1], 1);
    @(negedge aclk);
    check_eq("clr_count_on", m_gated[127:64], 1);
    m_issue(1, OP_HALT, 0);
    m_window(1, 3, en, pulses);
    check_eq("clr_halt_pulse", 64'(pulses), 1);

    // Narrow build: out-of-range channel, then counter wrap
    s_issue(1, OP_STEP, 5);
    s_window(4, en, pulses);
    check_eq("oor_en",    64'(en), 0);
    check_eq("oor_pulse", 64'(pulses), 0);
    s_issue(0, OP_STEP, 254);
    s_window(258, en, pulses);
    check_eq("s254_en",    64'(en), 254);
    check_eq("s254_pulse", 64'(pulses), 1);
    check_eq("s254_gated", 64'(s_gated), 254);
    s_issue(0, OP_STEP, 3);
    s_window(6, en, pulses);
    check_eq("wrap_en",    64'(en), 3);
    check_eq("wrap_pulse", 64'(pulses), 1);
    check_eq("wrap_gated", 64'(s_gated), 1);

    // Asynchronous reset mid-STEP
    m_issue(0, OP_STEP, 10);
    @(negedge aclk);
    @(negedge aclk);
    check_eq("pre_rst_en", m_clk_en[0], 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_en",    m_clk_en, 0);
    check_eq("arst_busy",  m_busy, 0);
    check_eq("arst_rem",   m_rem[31:0], 0);
    check_eq("arst_gated", m_gated[63:0], 0);
    check_eq("arst_ready", m_cmd_ready, 0);
    @(negedge aclk); rst = 1'b0;
    @(negedge aclk);
    check_eq("post_rst_en",    m_clk_en, 0);
    check_eq("post_rst_done",  m_done, 0);
    check_eq("post_rst_ready", m_cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
